// File: rtl/particle_integrator_if.sv
// Control handshake and particle_buffer port-A bus between the physics integrator and its neighbours.
// master is the integrator side; slave is the controller/buffer side.
interface particle_integrator_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) ();
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic              we;
    logic              regce;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (
        input  start, rdata,
        output busy, done, addr, en, we, regce, wdata
    );

    modport slave (
        output start, rdata,
        input  busy, done, addr, en, we, regce, wdata
    );
endinterface

// File: rtl/particle_integrator.sv
// One semi-implicit Euler pass over every particle in particle_buffer per start pulse:
// read-modify-write of each word with gravity, velocity step and saturating wall bounce.
module particle_integrator #(
    parameter int NUM_PARTICLES = 1024,
    parameter int FIELD_W       = 16,
    parameter int X_MAX         = 319,
    parameter int Y_MAX         = 179,
    parameter int GRAVITY       = 1
) (
    input  logic                   clka,
    input  logic                   rstb,
    particle_integrator_if.master  bus
);
    localparam int F  = FIELD_W;
    localparam int W  = FIELD_W + 2;
    localparam int AW = $clog2(NUM_PARTICLES);
    localparam logic [AW-1:0]       LAST   = AW'(NUM_PARTICLES - 1);
    localparam logic signed [W-1:0] GRAV   = W'(GRAVITY);
    localparam logic signed [W-1:0] FMAX   = W'((2 ** (F - 1)) - 1);
    localparam logic signed [W-1:0] FMIN   = W'(-(2 ** (F - 1)));
    localparam logic signed [W-1:0] XMAX_S = W'(X_MAX);
    localparam logic signed [W-1:0] YMAX_S = W'(Y_MAX);

    typedef enum logic [2:0] {IDLE, RD, W1, W2, CALC, WR, DONE} state_t;

    state_t        state, state_next;
    logic [AW-1:0] index;
    logic [F-1:0]  px, py, vx, vy;
    logic [F-1:0]  px_new, py_new, vx_new, vy_new, vy1;

    logic signed [W-1:0] vx_ext, vy_ext, vy1_sum, vy1_sat, nx, ny;
    logic                x_bounce, y_bounce;

    logic          busy, done, en, we, regce;
    logic [AW-1:0] addr;
    logic [4*F-1:0] wdata;

    // Negating the most negative value would overflow, so it clamps to the most positive.
    function automatic logic [F-1:0] neg_sat(input logic [F-1:0] v);
        if (v == {1'b1, {(F-1){1'b0}}})
            return {1'b0, {(F-1){1'b1}}};
        else
            return -v;
    endfunction

    always_ff @(posedge clka) begin
        if (rstb) begin
            state <= IDLE;
            index <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.start)
                index <= '0;
            else if (state == WR && index != LAST)
                index <= index + AW'(1);
        end
    end

    always_ff @(posedge clka) begin
        if (state == W2) begin
            {px, py, vx, vy} <= bus.rdata;
        end else if (state == CALC) begin
            px <= px_new;
            py <= py_new;
            vx <= vx_new;
            vy <= vy_new;
        end
    end

    always_comb begin
        vx_ext  = {{2{vx[F-1]}}, vx};
        vy_ext  = {{2{vy[F-1]}}, vy};
        vy1_sum = vy_ext + GRAV;
        if (vy1_sum > FMAX)
            vy1_sat = FMAX;
        else if (vy1_sum < FMIN)
            vy1_sat = FMIN;
        else
            vy1_sat = vy1_sum;
        vy1 = vy1_sat[F-1:0];
        nx  = signed'({2'b00, px}) + vx_ext;
        ny  = signed'({2'b00, py}) + vy1_sat;
        // Landing exactly on 0 or the max is in range and keeps its velocity.
        x_bounce = nx[W-1] || (nx > XMAX_S);
        y_bounce = ny[W-1] || (ny > YMAX_S);
        px_new = nx[W-1] ? '0 : (nx > XMAX_S) ? F'(X_MAX) : nx[F-1:0];
        py_new = ny[W-1] ? '0 : (ny > YMAX_S) ? F'(Y_MAX) : ny[F-1:0];
        vx_new = x_bounce ? neg_sat(vx) : vx;
        vy_new = y_bounce ? neg_sat(vy1) : vy1;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        en         = 1'b0;
        we         = 1'b0;
        regce      = 1'b0;
        addr       = '0;
        wdata      = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start)
                    state_next = RD;
            end
            RD: begin
                en         = 1'b1;
                addr       = index;
                state_next = W1;
            end
            W1: begin
                regce      = 1'b1;
                state_next = W2;
            end
            W2:   state_next = CALC;
            CALC: state_next = WR;
            WR: begin
                en         = 1'b1;
                we         = 1'b1;
                addr       = index;
                wdata      = {px, py, vx, vy};
                state_next = (index == LAST) ? DONE : RD;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.en    = en;
    assign bus.we    = we;
    assign bus.regce = regce;
    assign bus.addr  = addr;
    assign bus.wdata = wdata;
endmodule

// File: tb/tb_particle_integrator.sv
// Directed bench for particle_integrator against a 2-cycle-latency particle_buffer model (N=4, F=16).
// Expected words are hand-computed; control timing comes from a per-cycle phase table.
module tb_particle_integrator;
    localparam int N  = 4;
    localparam int F  = 16;
    localparam int AW = 2;
    localparam int DW = 4 * F;

    logic clka = 1'b0;
    logic rstb;
    int   checks = 0;
    int   errors = 0;

    always #5 clka = ~clka;

    particle_integrator_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    particle_integrator #(
        .NUM_PARTICLES(N), .FIELD_W(F), .X_MAX(319), .Y_MAX(179), .GRAVITY(1)
    ) dut (
        .clka(clka),
        .rstb(rstb),
        .bus (bus.master)
    );

    // Behavioural buffer: ram stage on en, output register on regce; loader port for preset.
    logic [DW-1:0] mem [N];
    logic [DW-1:0] ram_data = '0;
    logic [DW-1:0] douta    = '0;
    logic          load_en  = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;

    always @(posedge clka) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (bus.en) begin
            if (bus.we)
                mem[bus.addr] <= bus.wdata;
            ram_data <= mem[bus.addr];
        end
        if (bus.regce)
            douta <= ram_data;
    end

    assign bus.rdata = douta;

    function automatic logic [DW-1:0] pw(input int px, input int py, input int vx, input int vy);
        return {16'(px), 16'(py), 16'(vx), 16'(vy)};
    endfunction

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input int a, input logic [DW-1:0] d);
        load_en   = 1'b1;
        load_addr = AW'(a);
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    function automatic logic [DW-1:0] ctrl_now();
        return DW'({bus.busy, bus.done, bus.en, bus.we, bus.regce, bus.addr});
    endfunction

    // Control vector required in cycle c of a pass whose start was sampled in cycle 0.
    function automatic logic [DW-1:0] ctrl_exp(input int c);
        int  k  = (c - 1) / 5;
        int  ph = (c - 1) % 5;
        bit  act = (c >= 1) && (c <= 5 * N);
        bit  e   = act && (ph == 0 || ph == 4);
        return DW'({(c >= 1 && c <= 5 * N + 1), (c == 5 * N + 1), e,
                    (act && ph == 4), (act && ph == 1), (e ? AW'(k) : AW'(0))});
    endfunction

    task automatic run_pass(input string name);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 5 * N + 1; c++) begin
            if (c == 5 * N + 1)
                check_output({name, "_done"}, DW'(bus.done), DW'(1));
            tick();
        end
        check_output({name, "_idle"}, DW'(bus.busy), DW'(0));
    endtask

    logic [DW-1:0] exp1 [N];
    logic [DW-1:0] exp2 [N];
    logic [DW-1:0] exp4 [N];

    initial begin
        exp1[0] = pw(13, 19, 3, -1);
        exp1[1] = pw(319, 179, -5, -5);
        exp1[2] = pw(0, 179, 4, -32767);
        exp1[3] = pw(0, 51, 32767, 1);
        exp2[0] = pw(16, 19, 3, 0);
        exp2[1] = pw(314, 175, -5, -4);
        exp2[2] = pw(4, 0, 4, 32766);
        exp2[3] = pw(319, 53, -32767, 2);
        exp4[0] = pw(319, 0, 3, -2);
        exp4[1] = pw(5, 179, 0, 0);
        exp4[2] = pw(193, 17, -7, 7);
        exp4[3] = pw(0, 0, 0, 32767);

        bus.start = 1'b0;
        rstb      = 1'b1;
        tick();
        tick();
        check_output("reset_ctrl", ctrl_now(), '0);
        check_output("reset_wdata", bus.wdata, '0);
        rstb = 1'b0;

        load_word(0, pw(10, 20, 3, -2));
        load_word(1, pw(318, 178, 5, 4));
        load_word(2, pw(1, 100, -4, 32767));
        load_word(3, pw(0, 50, -32768, 0));

        // Timing pass with stray starts at cycles 3 and 12.
        bus.start = 1'b1;
        tick();
        for (int c = 1; c <= 5 * N + 2; c++) begin
            check_output($sformatf("ctrl_c%0d", c), ctrl_now(), ctrl_exp(c));
            if (c % 5 == 0 && c <= 5 * N)
                check_output($sformatf("wdata_c%0d", c), bus.wdata, exp1[c / 5 - 1]);
            bus.start = (c == 3 || c == 12);
            tick();
        end
        bus.start = 1'b0;
        for (int i = 0; i < N; i++)
            check_output($sformatf("pass1_p%0d", i), mem[i], exp1[i]);

        run_pass("pass2");
        for (int i = 0; i < N; i++)
            check_output($sformatf("pass2_p%0d", i), mem[i], exp2[i]);

        // Reset sampled at the end of cycle 8, after particle 0 was written back.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 8; c++)
            tick();
        rstb = 1'b1;
        tick();
        check_output("midreset_ctrl", ctrl_now(), '0);
        check_output("midreset_wdata", bus.wdata, '0);
        rstb = 1'b0;
        tick();
        check_output("midreset_stays_idle", ctrl_now(), '0);
        check_output("midreset_p0_kept", mem[0], pw(19, 20, 3, 1));
        check_output("midreset_p1_untouched", mem[1], exp2[1]);

        load_word(0, pw(316, 2, 3, -3));
        load_word(1, pw(5, 179, 0, -1));
        load_word(2, pw(200, 10, -7, 6));
        load_word(3, pw(0, 0, 0, -32768));
        run_pass("pass4");
        for (int i = 0; i < N; i++)
            check_output($sformatf("pass4_p%0d", i), mem[i], exp4[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
